r_ptr_empty_level: RTL
======================

R_PTR_EMPTY_LEVEL -- requirements
Module: r_ptr_empty_level

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 4, meaning the number of memory address bits (FIFO depth is 2^ADDR_SIZE).
REQ-002 The block SHALL have parameter AE_THRESH, default 2, meaning the almost-empty threshold in entries (range 0 to 2^ADDR_SIZE).
REQ-003 The block SHALL have port r_clk, input, 1 bit: the read-domain clock. It is the only clock; all registers SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port r_rst, input, 1 bit: the read-domain reset, asynchronous and active-high.
REQ-005 The block SHALL have port r_syn_w_gray, input, ADDR_SIZE+1 bits: the write Gray pointer, already synchronized into r_clk.
REQ-006 The block SHALL have port r_inc, input, 1 bit: read request; 1 pops one entry.
REQ-007 The block SHALL have port r_addr, output, ADDR_SIZE bits: the memory read address.
REQ-008 The block SHALL have port r_gray, output, ADDR_SIZE+1 bits: the registered read Gray pointer, including the extra wrap MSb, sent to the write domain.
REQ-009 The block SHALL have port r_empty, output, 1 bit: registered FIFO-empty flag.
REQ-010 The block SHALL have port r_almost_empty, output, 1 bit: registered flag, 1 when level <= AE_THRESH.
REQ-011 The block SHALL have port r_level, output, ADDR_SIZE+1 bits: registered occupancy, 0 to 2^ADDR_SIZE, as seen from the read domain.
REQ-012 The block SHALL have port r_underflow, output, 1 bit: a one-cycle pulse, 1 when r_inc was asserted while r_empty=1.

Function
REQ-013 The block SHALL hold an internal ADDR_SIZE+1-bit binary read pointer r_bin and drive r_addr = r_bin[ADDR_SIZE-1:0].
REQ-014 The block SHALL compute next binary = r_bin + (r_inc & ~r_empty), modulo 2^(ADDR_SIZE+1).
REQ-015 The block SHALL compute next Gray = (next binary >> 1) XOR next binary; r_bin and r_gray SHALL register next binary and next Gray every cycle.
REQ-016 The next empty value SHALL be 1 iff next Gray == r_syn_w_gray, with all ADDR_SIZE+1 bits equal; r_empty SHALL register it.
REQ-017 The block SHALL convert r_syn_w_gray to binary combinationally, where bit i = XOR of Gray bits ADDR_SIZE down to i.
REQ-018 The next level SHALL be (synced write binary - next binary) modulo 2^(ADDR_SIZE+1); r_level SHALL register it.
REQ-019 r_almost_empty SHALL register (next level <= AE_THRESH).
REQ-020 r_underflow SHALL register (r_inc & r_empty); the read pointer SHALL NOT advance on an underflow.
REQ-021 Latency: each flag and r_level SHALL reflect an r_syn_w_gray change exactly one r_clk edge later, with no further pipelining.
REQ-022 Simultaneous pop and write-pointer change in one cycle: the flags SHALL use both the new next binary and the current r_syn_w_gray.
REQ-023 Wrap-around: after pointer value 2^(ADDR_SIZE+1)-1, the pointer SHALL return to 0; r_addr SHALL wrap from 2^ADDR_SIZE-1 to 0 and toggle the pointer MSb.
REQ-024 At full occupancy, r_level SHALL equal 2^ADDR_SIZE and r_empty SHALL be 0.
REQ-025 The block SHALL have no memory and no data path; address generation and flag generation only.

Reset
REQ-026 When r_rst=1, the block SHALL immediately, without waiting for a clock, force r_bin=0, r_gray=0, r_addr=0, r_empty=1, r_almost_empty=1, r_level=0, r_underflow=0.
REQ-027 Reset asserted mid-operation SHALL discard the pointer state. The first edge after deassertion SHALL evaluate normally against r_syn_w_gray.

Verification (ADDR_SIZE=4, AE_THRESH=2)
REQ-028 Reset: assert r_rst between edges -> outputs SHALL take their reset values at once: r_empty=1, r_almost_empty=1, r_level=0, r_addr=0, r_gray=5'b00000.
REQ-029 Fill then drain: from reset, r_syn_w_gray=5'b00010 (binary 3), r_inc=0.
 -> next edge: r_empty=0, r_level=3, r_almost_empty=0.
 -> then three r_inc pulses: r_addr 0->1->2->3, r_level 2,1,0, r_almost_empty=1 from level 2, r_empty=1 after the third pop.
REQ-030 Full range: from reset, r_syn_w_gray=5'b11000 (binary 16).
 -> r_level=16, r_empty=0.
 -> then 16 pops: r_addr wraps 15->0, final r_gray=5'b11000, r_empty=1.
REQ-031 Underflow: with r_empty=1, r_inc=1 for 2 cycles -> r_underflow=1 for each of those 2 cycles, r_addr/r_gray unchanged, r_level stays 0.
REQ-032 Simultaneous: level=1 and r_inc=1 while r_syn_w_gray advances by 1 in the same cycle -> r_empty stays 0, r_level stays 1.
REQ-033 Reset mid-drain: r_rst pulsed at r_addr=7 -> all outputs SHALL return to reset values immediately; normal pops SHALL resume from r_addr=0.

Source files
------------

// File: rtl/r_ptr_empty_level.sv
// rtl/r_ptr_empty_level.sv - read-side FIFO pointer, empty/almost-empty flags and occupancy level
//
// Purpose:
//   Read-domain half of an asynchronous FIFO. It keeps the binary read pointer,
//   publishes its Gray form to the write domain, and derives registered empty,
//   almost-empty, occupancy and underflow indications from the write Gray
//   pointer that has already been synchronized into r_clk. There is no storage
//   and no data path in this block.
//
// Ports:
//   r_clk          in   read-domain clock (rising edge)
//   r_rst          in   asynchronous active-high reset
//   r_syn_w_gray   in   write Gray pointer, synchronized to r_clk (ADDR_SIZE+1 bits)
//   r_inc          in   pop request
//   r_addr         out  memory read address (ADDR_SIZE bits)
//   r_gray         out  registered read Gray pointer incl. wrap MSb
//   r_empty        out  registered empty flag
//   r_almost_empty out  registered flag, level <= AE_THRESH
//   r_level        out  registered occupancy, 0 .. 2^ADDR_SIZE
//   r_underflow    out  one-cycle pulse when r_inc is seen while empty

module r_ptr_empty_level #(
  parameter int ADDR_SIZE = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic [ADDR_SIZE:0]   r_syn_w_gray,
  input  logic                 r_inc,
  output logic [ADDR_SIZE-1:0] r_addr,
  output logic [ADDR_SIZE:0]   r_gray,
  output logic                 r_empty,
  output logic                 r_almost_empty,
  output logic [ADDR_SIZE:0]   r_level,
  output logic                 r_underflow
);

  localparam logic [ADDR_SIZE:0] AE_LIMIT = AE_THRESH[ADDR_SIZE:0];

  logic [ADDR_SIZE:0] r_bin;
  logic [ADDR_SIZE:0] bin_next;
  logic [ADDR_SIZE:0] gray_next;
  logic [ADDR_SIZE:0] w_bin;
  logic [ADDR_SIZE:0] level_next;
  logic               pop;

  // A request while empty is an underflow and must not move the pointer.
  assign pop       = r_inc & ~r_empty;
  assign bin_next  = r_bin + {{ADDR_SIZE{1'b0}}, pop};
  assign gray_next = (bin_next >> 1) ^ bin_next;

  // Gray to binary: each bit is the XOR of all Gray bits at and above it.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      w_bin[i] = ^(r_syn_w_gray >> i);
    end
  end

  // Modulo subtraction across the extra wrap bit yields 0 .. 2^ADDR_SIZE.
  assign level_next = w_bin - bin_next;

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_bin          <= '0;
      r_gray         <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_level        <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_bin          <= bin_next;
      r_gray         <= gray_next;
      r_empty        <= (gray_next == r_syn_w_gray);
      r_almost_empty <= (level_next <= AE_LIMIT);
      r_level        <= level_next;
      r_underflow    <= r_inc & r_empty;
    end
  end

  assign r_addr = r_bin[ADDR_SIZE-1:0];

endmodule
